// File: rtl/relu_bwd_mask_stream.sv
// ReLU backward mask stream.
// Records a pass bit (value >= 0) for every forward pre-activation in a
// circular buffer. Each incoming gradient is gated by the oldest stored bit
// and leaves through a one-deep registered valid/ready output stage.
module relu_bwd_mask_stream #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fwd_valid,
  input  logic signed [W-1:0]      fwd_value,
  output logic                     fwd_ready,
  input  logic                     grad_in_valid,
  input  logic signed [W-1:0]      grad_in_data,
  output logic                     grad_in_ready,
  output logic                     grad_out_valid,
  output logic signed [W-1:0]      grad_out_data,
  input  logic                     grad_out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   mask_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [DEPTH-1:0] mask_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             push, pop, out_free;

  // Handshake qualifiers; full/empty come from the count alone.
  always_comb begin
    out_free      = !out_valid_q || grad_out_ready;
    fwd_ready     = rst_n && (count_q < DepthC);
    grad_in_ready = rst_n && !flush && (count_q != '0) && out_free;
    // fwd_ready ignores flush, so the push is squashed here instead.
    push          = fwd_valid && fwd_ready && !flush;
    pop           = grad_in_valid && grad_in_ready;
  end

  // Next-state for pointers, occupancy and the output stage.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop) begin
        out_data_d  = mask_q[rd_ptr_q] ? grad_in_data : '0;
        out_valid_d = 1'b1;
      end else if (grad_out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Mask storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (push) mask_q[wr_ptr_q] <= ~fwd_value[W-1];
  end

  assign grad_out_valid = out_valid_q;
  assign grad_out_data  = out_data_q;
  assign mask_count     = count_q;

endmodule

// File: tb/tb_relu_bwd_mask_stream.sv
// Directed bench for relu_bwd_mask_stream: table-driven basic stream plus
// hand-written sequences for full, backpressure, wrap, flush and reset.
module tb_relu_bwd_mask_stream;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n, fwd_valid, fwd_ready, grad_in_valid, grad_in_ready;
  logic             grad_out_valid, grad_out_ready, flush;
  logic [W-1:0]     fwd_value, grad_in_data, grad_out_data;
  logic [$clog2(DEPTH):0] mask_count;

  int n_cmp  = 0;
  int n_fail = 0;

  relu_bwd_mask_stream #(.W(W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fwd_valid      (fwd_valid),
    .fwd_value      (fwd_value),
    .fwd_ready      (fwd_ready),
    .grad_in_valid  (grad_in_valid),
    .grad_in_data   (grad_in_data),
    .grad_in_ready  (grad_in_ready),
    .grad_out_valid (grad_out_valid),
    .grad_out_data  (grad_out_data),
    .grad_out_ready (grad_out_ready),
    .flush          (flush),
    .mask_count     (mask_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic [31:0] fval;
    logic        gv;
    logic [31:0] gd;
    logic        ordy;
    logic        fr;
    logic        gir;
    logic        ov;
    logic [31:0] od;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and checks happen in the low phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    fwd_valid = 1'b0; grad_in_valid = 1'b0; flush = 1'b0; grad_out_ready = 1'b1;
  endtask

  task automatic push(input logic [31:0] v);
    idle(); fwd_valid = 1'b1; fwd_value = v; tick();
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; tick(); flush = 1'b0;
  endtask

  logic    q [$];
  logic    m;
  logic [31:0] v, g, exp_prev;

  initial begin
    rst_n = 1'b0; fwd_value = '0; grad_in_data = '0;
    idle();
    @(negedge clk);
    tick();
    fwd_valid = 1'b1; grad_in_valid = 1'b1;
    #1;
    chk("rst_fwd_ready", 32'(fwd_ready), 32'd0);
    chk("rst_grad_in_ready", 32'(grad_in_ready), 32'd0);
    chk("rst_out_valid", 32'(grad_out_valid), 32'd0);
    chk("rst_out_data", grad_out_data, 32'd0);
    chk("rst_count", 32'(mask_count), 32'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // Basic stream: masks 1,0,1,0 -> outputs 10,0,30,0; then MSB-set gradient passes.
    tbl[0]  = '{1'b1, 32'd5,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  8'd0};
    tbl[1]  = '{1'b1, 32'hFFFFFFFD,   1'b0, 32'd0,          1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  8'd1};
    tbl[2]  = '{1'b1, 32'd0,          1'b0, 32'd0,          1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  8'd2};
    tbl[3]  = '{1'b1, 32'h80000000,   1'b0, 32'd0,          1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  8'd3};
    tbl[4]  = '{1'b0, 32'd0,          1'b1, 32'd10,         1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  8'd4};
    tbl[5]  = '{1'b0, 32'd0,          1'b1, 32'd20,         1'b1, 1'b1, 1'b1, 1'b1, 32'd10, 8'd3};
    tbl[6]  = '{1'b0, 32'd0,          1'b1, 32'd30,         1'b1, 1'b1, 1'b1, 1'b1, 32'd0,  8'd2};
    tbl[7]  = '{1'b0, 32'd0,          1'b1, 32'd40,         1'b1, 1'b1, 1'b1, 1'b1, 32'd30, 8'd1};
    tbl[8]  = '{1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b1, 32'd0,  8'd0};
    tbl[9]  = '{1'b1, 32'd1,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  8'd0};
    tbl[10] = '{1'b0, 32'd0,          1'b1, 32'h80000000,   1'b1, 1'b1, 1'b1, 1'b0, 32'd0,  8'd1};
    tbl[11] = '{1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b1, 32'h80000000, 8'd0};
    tbl[12] = '{1'b0, 32'd0,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0, 1'b0, 32'h80000000, 8'd0};
    for (int i = 0; i < 13; i++) begin
      fwd_valid = tbl[i].fv; fwd_value = tbl[i].fval;
      grad_in_valid = tbl[i].gv; grad_in_data = tbl[i].gd;
      grad_out_ready = tbl[i].ordy; flush = 1'b0;
      #1;
      chk($sformatf("t1[%0d]_fwd_ready", i), 32'(fwd_ready), 32'(tbl[i].fr));
      chk($sformatf("t1[%0d]_grad_in_ready", i), 32'(grad_in_ready), 32'(tbl[i].gir));
      chk($sformatf("t1[%0d]_out_valid", i), 32'(grad_out_valid), 32'(tbl[i].ov));
      chk($sformatf("t1[%0d]_out_data", i), grad_out_data, tbl[i].od);
      chk($sformatf("t1[%0d]_count", i), 32'(mask_count), 32'(tbl[i].cnt));
      tick();
    end

    // Full: DEPTH pushes close fwd_ready; a pop reopens it only a cycle later.
    for (int i = 0; i < int'(DEPTH); i++) push(32'(i));
    idle(); #1;
    chk("full_count", 32'(mask_count), DEPTH);
    chk("full_fwd_ready", 32'(fwd_ready), 32'd0);
    fwd_valid = 1'b1; fwd_value = 32'd100; grad_in_valid = 1'b1; grad_in_data = 32'd5;
    #1;
    chk("full_pop_cycle_fwd_ready", 32'(fwd_ready), 32'd0);
    chk("full_pop_cycle_grad_in_ready", 32'(grad_in_ready), 32'd1);
    tick();
    idle(); #1;
    chk("after_pop_fwd_ready", 32'(fwd_ready), 32'd1);
    chk("after_pop_count", 32'(mask_count), DEPTH - 1);
    chk("after_pop_out_data", grad_out_data, 32'd5);
    do_flush();

    // Backpressure: output 7 held while grad_out_ready is low.
    push(32'd4); push(32'd8);
    idle(); grad_in_valid = 1'b1; grad_in_data = 32'd7; tick();
    grad_out_ready = 1'b0; grad_in_data = 32'd9; #1;
    chk("bp_grad_in_ready", 32'(grad_in_ready), 32'd0);
    chk("bp_out_valid", 32'(grad_out_valid), 32'd1);
    chk("bp_out_data", grad_out_data, 32'd7);
    tick(); #1;
    chk("bp_hold_data", grad_out_data, 32'd7);
    chk("bp_hold_count", 32'(mask_count), 32'd1);
    tick(); #1;
    chk("bp_hold2_data", grad_out_data, 32'd7);
    chk("bp_hold2_valid", 32'(grad_out_valid), 32'd1);
    grad_out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(grad_in_ready), 32'd1);
    tick();
    idle(); #1;
    chk("bp_next_data", grad_out_data, 32'd9);
    chk("bp_next_valid", 32'(grad_out_valid), 32'd1);
    chk("bp_next_count", 32'(mask_count), 32'd0);
    tick(); #1;
    chk("bp_drain_valid", 32'(grad_out_valid), 32'd0);

    // Pointer wrap: 3*DEPTH simultaneous push+pop at occupancy 1.
    q.delete();
    push(32'd3); q.push_back(1'b1);
    exp_prev = '0;
    for (int k = 0; k < 3 * int'(DEPTH); k++) begin
      v = (k % 3 == 0) ? -32'(k) : 32'(k * 7);
      g = 32'(k * 13 + 1);
      fwd_valid = 1'b1; fwd_value = v; grad_in_valid = 1'b1; grad_in_data = g;
      grad_out_ready = 1'b1; flush = 1'b0;
      #1;
      chk($sformatf("wrap[%0d]_count", k), 32'(mask_count), 32'd1);
      chk($sformatf("wrap[%0d]_grad_in_ready", k), 32'(grad_in_ready), 32'd1);
      if (k > 0) chk($sformatf("wrap[%0d]_out_data", k), grad_out_data, exp_prev);
      q.push_back(~v[31]);
      m = q.pop_front();
      exp_prev = m ? g : 32'd0;
      tick();
    end
    idle(); #1;
    chk("wrap_last_data", grad_out_data, exp_prev);
    chk("wrap_last_count", 32'(mask_count), 32'd1);
    do_flush();

    // Flush with 10 stored masks and a pending output; push/pop that cycle ignored.
    for (int i = 0; i < 11; i++) push(32'(i * 2));
    idle(); grad_in_valid = 1'b1; grad_in_data = 32'd21; tick();
    fwd_valid = 1'b1; fwd_value = 32'd1; grad_out_ready = 1'b0; flush = 1'b1; #1;
    chk("fl_pre_count", 32'(mask_count), 32'd10);
    chk("fl_pre_valid", 32'(grad_out_valid), 32'd1);
    chk("fl_cycle_grad_in_ready", 32'(grad_in_ready), 32'd0);
    tick();
    idle(); #1;
    chk("fl_count", 32'(mask_count), 32'd0);
    chk("fl_out_valid", 32'(grad_out_valid), 32'd0);
    chk("fl_grad_in_ready", 32'(grad_in_ready), 32'd0);

    // Reset mid-stream, then a fresh push/pop pair.
    push(32'd1); push(32'd2); push(32'd3);
    idle(); grad_in_valid = 1'b1; grad_in_data = 32'd50; tick();
    rst_n = 1'b0; fwd_valid = 1'b1; fwd_value = 32'd9; #1;
    chk("mrst_fwd_ready", 32'(fwd_ready), 32'd0);
    chk("mrst_grad_in_ready", 32'(grad_in_ready), 32'd0);
    tick();
    rst_n = 1'b1; idle(); #1;
    chk("mrst_count", 32'(mask_count), 32'd0);
    chk("mrst_out_valid", 32'(grad_out_valid), 32'd0);
    chk("mrst_out_data", grad_out_data, 32'd0);
    push(32'hFFFFFFFB);
    fwd_valid = 1'b1; fwd_value = 32'd6; grad_in_valid = 1'b1; grad_in_data = 32'd33; #1;
    chk("post_rst_grad_in_ready", 32'(grad_in_ready), 32'd1);
    tick();
    idle(); grad_in_valid = 1'b1; grad_in_data = 32'd44; #1;
    chk("post_rst_out0_valid", 32'(grad_out_valid), 32'd1);
    chk("post_rst_out0_data", grad_out_data, 32'd0);
    chk("post_rst_count", 32'(mask_count), 32'd1);
    tick();
    idle(); #1;
    chk("post_rst_out1_data", grad_out_data, 32'd44);
    chk("post_rst_final_count", 32'(mask_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
